xbar_onehot_cmd_gen_seq: RTL and testbench

- Initiator-side front end for the one-hot sequential crossbar.
- Accepts per-source requests, each carrying a binary destination ID and data.
- Resolves output conflicts with one round-robin arbiter per output port.
- Emits registered valid, data and one-hot command buses in exactly the format the crossbar consumes: cmd bit [i*NUM_OUTPUT_DATA + j] = route input i to output j.

---
 rtl/xbar_onehot_cmd_gen_seq_pkg.sv | 20 ++
 rtl/xbar_onehot_cmd_gen_seq_if.sv | 26 ++
 rtl/xbar_onehot_cmd_gen_seq_rr_arbiter_seq.sv | 41 ++++
 rtl/xbar_onehot_cmd_gen_seq.sv | 108 ++++++++++
 tb/tb_xbar_onehot_cmd_gen_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_onehot_cmd_gen_seq_pkg.sv
// Shared sizing and one-hot command helpers for the one-hot sequential crossbar initiator.
package xbar_onehot_cmd_gen_seq_pkg;

  localparam int unsigned NUM_INPUT_DATA  = 8;
  localparam int unsigned NUM_OUTPUT_DATA = 8;
  localparam int unsigned DEST_WIDTH      = $clog2(NUM_OUTPUT_DATA);
  localparam int unsigned PTR_WIDTH       = $clog2(NUM_INPUT_DATA);
  localparam int unsigned CMD_WIDTH       = NUM_INPUT_DATA * NUM_OUTPUT_DATA;
  localparam int unsigned CNT_WIDTH       = 16;

  typedef logic [DEST_WIDTH-1:0]      dest_t;
  typedef logic [NUM_OUTPUT_DATA-1:0] cmd_row_t;

  // One command row: bit j set routes this source to crossbar output j.
  function automatic cmd_row_t onehot_row(input dest_t dest);
    onehot_row       = '0;
    onehot_row[dest] = 1'b1;
  endfunction

endpackage

// File: rtl/xbar_onehot_cmd_gen_seq_if.sv
// Request and issue buses between the sources, the command generator and the crossbar.
interface xbar_onehot_cmd_gen_seq_if
  import xbar_onehot_cmd_gen_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic [NUM_INPUT_DATA-1:0]            i_req_valid;
  logic [NUM_INPUT_DATA*DEST_WIDTH-1:0] i_req_dest;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_INPUT_DATA-1:0]            o_req_ready;
  logic [NUM_INPUT_DATA-1:0]            o_valid;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] o_data_bus;
  logic [CMD_WIDTH-1:0]                 o_cmd;

  modport master (
    output i_req_valid, i_req_dest, i_req_data,
    input  o_req_ready, o_valid, o_data_bus, o_cmd
  );

  modport slave (
    input  i_req_valid, i_req_dest, i_req_data,
    output o_req_ready, o_valid, o_data_bus, o_cmd
  );

endinterface

// File: rtl/xbar_onehot_cmd_gen_seq_rr_arbiter_seq.sv
// Round-robin arbiter for one crossbar output; the pointer moves past each winner.
module xbar_onehot_cmd_gen_seq_rr_arbiter_seq
  import xbar_onehot_cmd_gen_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_upd_en,
  input  logic [NUM_INPUT_DATA-1:0] i_req,
  output logic [NUM_INPUT_DATA-1:0] o_gnt_c
);

  logic [PTR_WIDTH-1:0] r_ptr;
  logic [PTR_WIDTH-1:0] w_idx;
  logic [PTR_WIDTH-1:0] w_win;
  logic                 w_found;

  // Scan from the pointer upward; the index wraps naturally since the source count is a power of 2.
  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned n = 0; n < NUM_INPUT_DATA; n++) begin
      w_idx = r_ptr + PTR_WIDTH'(n);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        w_win          = w_idx;
        o_gnt_c[w_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_upd_en && w_found) begin
      r_ptr <= w_win + PTR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/xbar_onehot_cmd_gen_seq.sv
// Initiator front end: decodes per-source destinations, arbitrates per output and
// issues registered valid/data/one-hot command buses for the one-hot sequential crossbar.
module xbar_onehot_cmd_gen_seq
  import xbar_onehot_cmd_gen_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
)
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  xbar_onehot_cmd_gen_seq_if.slave     bus,
  output logic                         o_en,
  output logic [CNT_WIDTH-1:0]         o_grant_cnt
);

  localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

  dest_t                                w_dest    [NUM_INPUT_DATA];
  logic [NUM_INPUT_DATA-1:0]            w_req_mat [NUM_OUTPUT_DATA];
  logic [NUM_INPUT_DATA-1:0]            w_gnt     [NUM_OUTPUT_DATA];
  logic [NUM_INPUT_DATA-1:0]            w_ready;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] w_data_nxt;
  logic [CMD_WIDTH-1:0]                 w_cmd_nxt;
  logic [SUM_WIDTH-1:0]                 w_cnt_sum;
  logic [CNT_WIDTH-1:0]                 w_cnt_nxt;

  logic [NUM_INPUT_DATA-1:0]            r_valid;
  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] r_data;
  logic [CMD_WIDTH-1:0]                 r_cmd;
  logic                                 r_en;
  logic [CNT_WIDTH-1:0]                 r_cnt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_INPUT_DATA; i++) begin
      w_dest[i] = bus.i_req_dest[i*DEST_WIDTH +: DEST_WIDTH];
    end
  end

  // Request matrix: row j holds every source currently targeting output j.
  always_comb begin
    for (int unsigned j = 0; j < NUM_OUTPUT_DATA; j++) begin
      w_req_mat[j] = '0;
      for (int unsigned i = 0; i < NUM_INPUT_DATA; i++) begin
        w_req_mat[j][i] = bus.i_req_valid[i] && (w_dest[i] == DEST_WIDTH'(j));
      end
    end
  end

  for (genvar j = 0; j < NUM_OUTPUT_DATA; j++) begin : g_arb
    xbar_onehot_cmd_gen_seq_rr_arbiter_seq u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_upd_en (i_en),
      .i_req    (w_req_mat[j]),
      .o_gnt_c  (w_gnt[j])
    );
  end

  // A source is accepted only by the arbiter of its own destination, and never during reset.
  always_comb begin
    w_ready = '0;
    for (int unsigned i = 0; i < NUM_INPUT_DATA; i++) begin
      w_ready[i] = i_en && rst && w_gnt[w_dest[i]][i];
    end
  end

  always_comb begin
    w_data_nxt = '0;
    w_cmd_nxt  = '0;
    for (int unsigned i = 0; i < NUM_INPUT_DATA; i++) begin
      if (w_ready[i]) begin
        w_data_nxt[i*DATA_WIDTH +: DATA_WIDTH]          = bus.i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_cmd_nxt[i*NUM_OUTPUT_DATA +: NUM_OUTPUT_DATA] = onehot_row(w_dest[i]);
      end
    end
  end

  // Extra carry bit detects overflow so the count pins at all-ones.
  always_comb begin
    w_cnt_sum = {1'b0, r_cnt} + SUM_WIDTH'($countones(w_ready));
    w_cnt_nxt = w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_cmd   <= '0;
      r_en    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_ready;
      r_data  <= w_data_nxt;
      r_cmd   <= w_cmd_nxt;
      r_en    <= i_en;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.o_req_ready = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_data_bus  = r_data;
  assign bus.o_cmd       = r_cmd;
  assign o_en            = r_en;
  assign o_grant_cnt     = r_cnt;

endmodule

// File: tb/tb_xbar_onehot_cmd_gen_seq.sv
// Directed bench for the one-hot crossbar command generator: permutation, hotspot
// fairness, partial conflict, enable gating, async reset and counter saturation.
module tb_xbar_onehot_cmd_gen_seq;
  import xbar_onehot_cmd_gen_seq_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NI = NUM_INPUT_DATA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_en = 1'b0;
  logic        o_en;
  logic [15:0] o_grant_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [NI-1:0]         vld;
  logic [DEST_WIDTH-1:0] dst [NI];
  logic [DW-1:0]         dat [NI];

  xbar_onehot_cmd_gen_seq_if #(.DATA_WIDTH(DW)) bus ();

  xbar_onehot_cmd_gen_seq #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .bus         (bus.slave),
    .o_en        (o_en),
    .o_grant_cnt (o_grant_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (bus.i_req_valid[i])
          assert (int'(bus.i_req_dest[i*DEST_WIDTH +: DEST_WIDTH]) < int'(NUM_OUTPUT_DATA))
            else $error("illegal destination on source %0d", i);
      end
    end
  end

  task automatic drive();
    bus.i_req_valid = vld;
    for (int i = 0; i < NI; i++) begin
      bus.i_req_dest[i*DEST_WIDTH +: DEST_WIDTH] = dst[i];
      bus.i_req_data[i*DW +: DW]                 = dat[i];
    end
  endtask

  task automatic set_perm();
    vld = '1;
    for (int i = 0; i < NI; i++) dst[i] = DEST_WIDTH'(NI - 1 - i);
  endtask

  task automatic set_hot(input logic [DEST_WIDTH-1:0] d);
    vld = '1;
    for (int i = 0; i < NI; i++) dst[i] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    vld = '0;
    drive();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    i_en = 1'b1;
    set_perm();
    drive();
    #2;
    n_vec++; if (bus.o_req_ready !== 8'h00) begin n_err++; $display("FAIL reset_ready: got %h want 00", bus.o_req_ready); end
    n_vec++; if (bus.o_valid !== 8'h00) begin n_err++; $display("FAIL reset_valid: got %h want 00", bus.o_valid); end
    n_vec++; if (bus.o_cmd !== 64'h0) begin n_err++; $display("FAIL reset_cmd: got %h want 0", bus.o_cmd); end
    n_vec++; if (bus.o_data_bus !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.o_data_bus); end
    n_vec++; if (o_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", o_en); end
    n_vec++; if (o_grant_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", o_grant_cnt); end
    @(posedge clk); #1;
    n_vec++; if (bus.o_valid !== 8'h00) begin n_err++; $display("FAIL reset_hold_valid: got %h want 00", bus.o_valid); end
    n_vec++; if (o_grant_cnt !== 16'h0) begin n_err++; $display("FAIL reset_hold_cnt: got %h want 0", o_grant_cnt); end
    @(negedge clk);
    rst = 1'b1;
    vld = '0;
    drive();
  endtask

  task automatic test_permutation();
    logic [63:0]      ec;
    logic [NI*DW-1:0] ed;
    @(negedge clk);
    set_perm();
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'hFF) begin n_err++; $display("FAIL perm_ready: got %h want ff", bus.o_req_ready); end
    @(posedge clk); #1;
    ec = '0;
    ed = '0;
    for (int i = 0; i < NI; i++) begin
      ec[i*8 + (7 - i)] = 1'b1;
      ed[i*DW +: DW]    = dat[i];
    end
    n_vec++; if (bus.o_valid !== 8'hFF) begin n_err++; $display("FAIL perm_valid: got %h want ff", bus.o_valid); end
    n_vec++; if (bus.o_cmd !== ec) begin n_err++; $display("FAIL perm_cmd: got %h want %h", bus.o_cmd, ec); end
    n_vec++; if (bus.o_data_bus !== ed) begin n_err++; $display("FAIL perm_data: got %h want %h", bus.o_data_bus, ed); end
    n_vec++; if (o_grant_cnt !== 16'd8) begin n_err++; $display("FAIL perm_cnt: got %0d want 8", o_grant_cnt); end
    n_vec++; if (o_en !== 1'b1) begin n_err++; $display("FAIL perm_en: got %b want 1", o_en); end
    vld = '0;
    drive();
  endtask

  task automatic test_hotspot();
    logic [63:0]      ec;
    logic [NI-1:0]    er;
    logic [NI*DW-1:0] ed;
    do_reset();
    for (int c = 0; c < NI; c++) begin
      @(negedge clk);
      set_hot(3'd3);
      for (int i = 0; i < NI; i++) vld[i] = (i >= c);
      drive();
      #1;
      er = NI'(1 << c);
      n_vec++; if (bus.o_req_ready !== er) begin n_err++; $display("FAIL hot_ready[%0d]: got %h want %h", c, bus.o_req_ready, er); end
      @(posedge clk); #1;
      ec = '0;
      ec[c*8 + 3] = 1'b1;
      ed = '0;
      ed[c*DW +: DW] = dat[c];
      n_vec++; if (bus.o_valid !== er) begin n_err++; $display("FAIL hot_valid[%0d]: got %h want %h", c, bus.o_valid, er); end
      n_vec++; if (bus.o_cmd !== ec) begin n_err++; $display("FAIL hot_cmd[%0d]: got %h want %h", c, bus.o_cmd, ec); end
      n_vec++; if (bus.o_data_bus !== ed) begin n_err++; $display("FAIL hot_data[%0d]: got %h want %h", c, bus.o_data_bus, ed); end
      n_vec++; if (o_grant_cnt !== 16'(c + 1)) begin n_err++; $display("FAIL hot_cnt[%0d]: got %0d want %0d", c, o_grant_cnt, c + 1); end
    end
    @(negedge clk);
    set_hot(3'd3);
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'h01) begin n_err++; $display("FAIL hot_wrap_ready: got %h want 01", bus.o_req_ready); end
    @(posedge clk); #1;
    vld = '0;
    drive();
  endtask

  task automatic test_partial();
    logic [63:0]      ec;
    logic [NI*DW-1:0] ed;
    do_reset();
    @(negedge clk);
    vld = 8'b0000_0100;
    dst[2] = 3'd2;
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'h04) begin n_err++; $display("FAIL part_seed_ready: got %h want 04", bus.o_req_ready); end
    @(negedge clk);
    vld = 8'b0011_0010;
    dst[1] = 3'd2; dst[5] = 3'd2; dst[4] = 3'd6;
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'b0011_0000) begin n_err++; $display("FAIL part_ready: got %b want 00110000", bus.o_req_ready); end
    @(posedge clk); #1;
    ec = '0; ec[5*8 + 2] = 1'b1; ec[4*8 + 6] = 1'b1;
    ed = '0; ed[5*DW +: DW] = dat[5]; ed[4*DW +: DW] = dat[4];
    n_vec++; if (bus.o_valid !== 8'h30) begin n_err++; $display("FAIL part_valid: got %h want 30", bus.o_valid); end
    n_vec++; if (bus.o_cmd !== ec) begin n_err++; $display("FAIL part_cmd: got %h want %h", bus.o_cmd, ec); end
    n_vec++; if (bus.o_data_bus !== ed) begin n_err++; $display("FAIL part_data: got %h want %h", bus.o_data_bus, ed); end
    @(negedge clk);
    vld = 8'b0000_0010;
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'h02) begin n_err++; $display("FAIL part_retry_ready: got %h want 02", bus.o_req_ready); end
    @(posedge clk); #1;
    ec = '0; ec[1*8 + 2] = 1'b1;
    n_vec++; if (bus.o_cmd !== ec) begin n_err++; $display("FAIL part_retry_cmd: got %h want %h", bus.o_cmd, ec); end
    n_vec++; if (o_grant_cnt !== 16'd4) begin n_err++; $display("FAIL part_cnt: got %0d want 4", o_grant_cnt); end
    vld = '0;
    drive();
  endtask

  task automatic test_enable();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      i_en = 1'b0;
      set_hot(3'd3);
      drive();
      #1;
      n_vec++; if (bus.o_req_ready !== 8'h00) begin n_err++; $display("FAIL en_ready[%0d]: got %h want 00", g, bus.o_req_ready); end
      n_vec++; if (o_en !== (g == 0)) begin n_err++; $display("FAIL en_lag_low[%0d]: got %b want %b", g, o_en, (g == 0)); end
      @(posedge clk); #1;
      n_vec++; if (bus.o_valid !== 8'h00) begin n_err++; $display("FAIL en_valid[%0d]: got %h want 00", g, bus.o_valid); end
      n_vec++; if (bus.o_cmd !== 64'h0) begin n_err++; $display("FAIL en_cmd[%0d]: got %h want 0", g, bus.o_cmd); end
      n_vec++; if (o_en !== 1'b0) begin n_err++; $display("FAIL en_oen[%0d]: got %b want 0", g, o_en); end
    end
    @(negedge clk);
    i_en = 1'b1;
    #1;
    n_vec++; if (bus.o_req_ready !== 8'h01) begin n_err++; $display("FAIL en_resume_ready: got %h want 01", bus.o_req_ready); end
    n_vec++; if (o_en !== 1'b0) begin n_err++; $display("FAIL en_lag_high: got %b want 0", o_en); end
    @(posedge clk); #1;
    n_vec++; if (o_en !== 1'b1) begin n_err++; $display("FAIL en_oen_high: got %b want 1", o_en); end
    n_vec++; if (bus.o_valid !== 8'h01) begin n_err++; $display("FAIL en_resume_valid: got %h want 01", bus.o_valid); end
    n_vec++; if (o_grant_cnt !== 16'd1) begin n_err++; $display("FAIL en_cnt: got %0d want 1", o_grant_cnt); end
    vld = '0;
    drive();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    set_perm();
    drive();
    @(posedge clk); #1;
    n_vec++; if (bus.o_valid !== 8'hFF) begin n_err++; $display("FAIL arst_pre_valid: got %h want ff", bus.o_valid); end
    #2;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.o_valid !== 8'h00) begin n_err++; $display("FAIL arst_valid: got %h want 00", bus.o_valid); end
    n_vec++; if (bus.o_cmd !== 64'h0) begin n_err++; $display("FAIL arst_cmd: got %h want 0", bus.o_cmd); end
    n_vec++; if (bus.o_data_bus !== '0) begin n_err++; $display("FAIL arst_data: got %h want 0", bus.o_data_bus); end
    n_vec++; if (o_grant_cnt !== 16'h0) begin n_err++; $display("FAIL arst_cnt: got %h want 0", o_grant_cnt); end
    n_vec++; if (bus.o_req_ready !== 8'h00) begin n_err++; $display("FAIL arst_ready: got %h want 00", bus.o_req_ready); end
    @(negedge clk);
    rst = 1'b1;
    set_hot(3'd3);
    drive();
    #1;
    n_vec++; if (bus.o_req_ready !== 8'h01) begin n_err++; $display("FAIL arst_restart_ready: got %h want 01", bus.o_req_ready); end
    @(posedge clk); #1;
    n_vec++; if (o_grant_cnt !== 16'd1) begin n_err++; $display("FAIL arst_restart_cnt: got %0d want 1", o_grant_cnt); end
    vld = '0;
    drive();
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    set_perm();
    drive();
    for (int n = 1; n <= 8200; n++) begin
      @(posedge clk); #1;
      if (n == 8191) begin
        n_vec++; if (o_grant_cnt !== 16'hFFF8) begin n_err++; $display("FAIL sat_near: got %h want fff8", o_grant_cnt); end
      end
      if (n == 8192) begin
        n_vec++; if (o_grant_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hit: got %h want ffff", o_grant_cnt); end
      end
      if (n == 8200) begin
        n_vec++; if (o_grant_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", o_grant_cnt); end
        n_vec++; if (bus.o_valid !== 8'hFF) begin n_err++; $display("FAIL sat_valid: got %h want ff", bus.o_valid); end
      end
    end
    vld = '0;
    drive();
  endtask

  initial begin
    vld = '0;
    for (int i = 0; i < NI; i++) begin
      dst[i] = '0;
      dat[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_1111 + 32'h1;
    end
    drive();
    test_reset();
    test_permutation();
    test_hotspot();
    test_partial();
    test_enable();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
